// File: rtl/sensor_conditioner_if.sv
// ----------------------------------------------------------------------------
// sensor_conditioner_if
// Signal bundle between the car-detector front end and the conditioner.
//   raw_a, raw_b       : asynchronous detector inputs for roads A and B
//   Sa, Sb             : conditioned traffic requests for the light controller
//   fault_a, fault_b   : sticky stuck-sensor flags
// Modports: master drives the raw inputs, slave (the conditioner) drives the
// conditioned requests and fault flags.
// ----------------------------------------------------------------------------
interface sensor_conditioner_if;
   logic raw_a;
   logic raw_b;
   logic Sa;
   logic Sb;
   logic fault_a;
   logic fault_b;

   modport master (
      output raw_a,
      output raw_b,
      input  Sa,
      input  Sb,
      input  fault_a,
      input  fault_b
   );

   modport slave (
      input  raw_a,
      input  raw_b,
      output Sa,
      output Sb,
      output fault_a,
      output fault_b
   );
endinterface

// File: rtl/sensor_conditioner.sv
// ----------------------------------------------------------------------------
// sensor_conditioner
// Conditions two asynchronous car-detector inputs into clean traffic requests.
// Each channel synchronizes its input, debounces it (DB cycles high needed),
// stretches the request HOLD cycles after the input falls, and flags a stuck
// sensor after STUCK continuous high cycles (request kept asserted, fail-safe).
// Ports:
//   clk    : single clock, rising edge
//   reset  : synchronous, active-high
//   bus    : sensor_conditioner_if.slave (raw_a/raw_b in, Sa/Sb/fault_a/fault_b out)
// Parameters: n (counter width), DB, HOLD, STUCK (all 1 .. 2^n-1).
// ----------------------------------------------------------------------------
module sensor_conditioner #(
   parameter int unsigned n     = 13,
   parameter int unsigned DB    = 8,
   parameter int unsigned HOLD  = 200,
   parameter int unsigned STUCK = 4000
) (
   input  logic                clk,
   input  logic                reset,
   sensor_conditioner_if.slave bus
);

   localparam longint unsigned CNT_MAX = (64'd1 << n) - 64'd1;

   // Reject thresholds that are zero or do not fit the counter width.
   generate
      if (n == 32'd0 || n > 32'd32 || DB == 32'd0 || HOLD == 32'd0 || STUCK == 32'd0 ||
          64'(DB) > CNT_MAX || 64'(HOLD) > CNT_MAX || 64'(STUCK) > CNT_MAX) begin : g_bad_params
         $error("sensor_conditioner: DB, HOLD and STUCK must be in 1 .. 2^n-1");
      end
   endgenerate

   localparam logic [n-1:0] ZERO_C   = n'(0);
   localparam logic [n-1:0] ONE_C    = n'(1);
   localparam logic [n-1:0] ALL1_C   = n'(CNT_MAX);
   localparam logic [n-1:0] DB_C     = n'(DB);
   localparam logic [n-1:0] HOLD_C   = n'(HOLD);
   localparam logic [n-1:0] STUCK_C  = n'(STUCK);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_QUAL   = 3'd1,
      ST_ACTIVE = 3'd2,
      ST_HOLDST = 3'd3,
      ST_FAULT  = 3'd4
   } state_t;

   logic [1:0] raw_s;
   logic [1:0] req_s;
   logic [1:0] flt_s;

   assign raw_s       = {bus.raw_b, bus.raw_a};
   assign bus.Sa      = req_s[0];
   assign bus.Sb      = req_s[1];
   assign bus.fault_a = flt_s[0];
   assign bus.fault_b = flt_s[1];

   for (genvar c = 0; c < 2; c++) begin : g_ch
      logic         sync1_q;
      logic         sync2_q;
      state_t       state_q, state_d;
      // One counter per channel: debounce count in QUAL, run length in
      // ACTIVE/FAULT (continuing from the debounce count), hold count in HOLDST.
      logic [n-1:0] cnt_q, cnt_d;
      logic [n-1:0] cnt_inc_s;
      logic [n-1:0] cnt_dec_s;
      logic         req_q, req_d;
      logic         flt_q, flt_d;

      // Saturating step values so the counter never wraps.
      assign cnt_inc_s = (cnt_q == ALL1_C) ? cnt_q : cnt_q + ONE_C;
      assign cnt_dec_s = (cnt_q == ZERO_C) ? cnt_q : cnt_q - ONE_C;

      // Synchronizer, FSM state, counter and registered outputs.
      always_ff @(posedge clk) begin
         if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= ZERO_C;
            req_q   <= 1'b0;
            flt_q   <= 1'b0;
         end else begin
            sync1_q <= raw_s[c];
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            flt_q   <= flt_d;
         end
      end

      // Next state, counter load and next output values; transitions win
      // over plain count events on the same edge.
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         req_d   = 1'b0;
         flt_d   = flt_q;
         case (state_q)
            ST_IDLE: begin
               if (sync2_q) begin
                  cnt_d = ONE_C;
                  if (DB_C == ONE_C) begin
                     state_d = ST_ACTIVE;
                     req_d   = 1'b1;
                  end else begin
                     state_d = ST_QUAL;
                  end
               end else begin
                  cnt_d = ZERO_C;
               end
            end
            ST_QUAL: begin
               if (!sync2_q) begin
                  state_d = ST_IDLE;
                  cnt_d   = ZERO_C;
               end else if (cnt_inc_s >= DB_C) begin
                  state_d = ST_ACTIVE;
                  cnt_d   = cnt_inc_s;
                  req_d   = 1'b1;
               end else begin
                  cnt_d = cnt_inc_s;
               end
            end
            ST_ACTIVE: begin
               req_d = 1'b1;
               if (!sync2_q) begin
                  state_d = ST_HOLDST;
                  cnt_d   = HOLD_C;
               end else if (cnt_inc_s >= STUCK_C) begin
                  state_d = ST_FAULT;
                  cnt_d   = cnt_inc_s;
                  flt_d   = 1'b1;
               end else begin
                  cnt_d = cnt_inc_s;
               end
            end
            ST_HOLDST: begin
               req_d = 1'b1;
               if (sync2_q) begin
                  state_d = ST_ACTIVE;
                  cnt_d   = ONE_C;
               end else if (cnt_dec_s == ZERO_C) begin
                  state_d = ST_IDLE;
                  cnt_d   = ZERO_C;
                  req_d   = 1'b0;
               end else begin
                  cnt_d = cnt_dec_s;
               end
            end
            ST_FAULT: begin
               // Keep requesting service while the sensor is stuck.
               req_d = 1'b1;
               flt_d = 1'b1;
               if (!sync2_q) begin
                  state_d = ST_HOLDST;
                  cnt_d   = HOLD_C;
               end else begin
                  cnt_d = cnt_inc_s;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = ZERO_C;
               req_d   = 1'b0;
            end
         endcase
      end

      assign req_s[c] = req_q;
      assign flt_s[c] = flt_q;
   end

endmodule
